// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {BOOT, RUN} fetch_state_e;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer holding {pc, instr} pairs in fetch order.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push_i,
  input  fetch_entry_t     data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // A pop frees a slot in the same cycle, so push into a full FIFO is fine with a pop.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = inc_ptr(rd_ptr_q);
      if (do_push) wr_ptr_d = inc_ptr(wr_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues in-order memory requests under a credit limit, buffers
// responses and hands them to the core; redirects flush and drop stale responses.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int SUM_W = CNT_W + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [31:0]      last_pc_q, last_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;
  logic [SUM_W-1:0] in_use;
  logic             credit_ok, gnt_fire, push, pop, fifo_nonempty;

  assign in_use        = SUM_W'(fifo_count) + SUM_W'(outstanding_q);
  assign credit_ok     = in_use < SUM_W'(FIFO_DEPTH);
  assign fifo_nonempty = fifo_count != '0;
  assign push_entry    = '{pc: resp_pc_q, instr: imem_rdata};

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Outstanding and buffered entries together never exceed FIFO_DEPTH, so a push always has room.
  always_comb begin
    imem_req    = (state_q == RUN) && !redirect_i && credit_ok;
    imem_addr   = fetch_pc_q;
    gnt_fire    = imem_req && imem_gnt;
    push        = imem_rvalid && !redirect_i && (discard_q == '0);
    instr_valid = fifo_nonempty && !redirect_i;
    pop         = instr_valid && instr_ready;
    instr       = fifo_nonempty ? fifo_head.instr : NOP_INSTR;
    instr_pc    = fifo_nonempty ? fifo_head.pc : last_pc_q;
    last_pc_d   = fifo_nonempty ? fifo_head.pc : last_pc_q;

    outstanding_d = outstanding_q;
    case ({gnt_fire, imem_rvalid})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    // Every response still owed by memory after a redirect belongs to the old stream.
    if (redirect_i) begin
      fetch_pc_d = word_align(redirect_pc);
      resp_pc_d  = word_align(redirect_pc);
      discard_d  = outstanding_d;
    end else begin
      if (gnt_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)     resp_pc_d  = resp_pc_q + 32'd4;
      if (imem_rvalid && (discard_q != '0)) discard_d = discard_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      last_pc_q     <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      last_pc_q     <= last_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk    (clk),
    .n_rst  (n_rst),
    .push_i (push),
    .data_i (push_entry),
    .pop_i  (pop),
    .flush_i(redirect_i),
    .head_o (fifo_head),
    .count_o(fifo_count)
  );

  push_never_full: assert property (@(posedge clk) disable iff (!n_rst)
    push |-> (fifo_count < CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: an in-order memory model with per-request latency plus a
// queue-based model of what the core should see each cycle.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .redirect_i (redirect_i),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  mreq_t       pend[$];
  logic [31:0] bufq[$];
  logic [31:0] consumed[$];
  logic [31:0] modelPc, lastPc;
  int          cyc, vectors, miscompares, gntCount;

  int          lat, holdLeft, rc1, rc2, readyOffFrom, readyOffTo;
  logic [31:0] holdAddr, rp1, rp2;

  logic        logReq[64];
  logic [31:0] logAddr[64];
  logic        logValid[64];
  logic [31:0] logPc[64];

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] getC(input int i);
    if (consumed.size() > i) return consumed[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic checkOutput(input logic expReq, input logic expValid);
    compare("imem_req", imem_req, expReq);
    compare("imem_addr", imem_addr, modelPc);
    compare("instr_valid", instr_valid, expValid);
    if (bufq.size() > 0) begin
      compare("instr_pc", instr_pc, bufq[0]);
      compare("instr", instr, ~bufq[0]);
    end else begin
      compare("instr_pc_hold", instr_pc, lastPc);
      compare("instr_nop", instr, NOP_INSTR);
    end
    if (cyc < 64) begin
      logReq[cyc]   = imem_req;
      logAddr[cyc]  = imem_addr;
      logValid[cyc] = instr_valid;
      logPc[cyc]    = instr_pc;
    end
  endtask

  // One cycle: drive inputs at the falling edge, check, then advance the model across the rising edge.
  task automatic applyStimulus(input int n);
    logic redir, rdy, rv, gnt, expReq, expValid;
    logic [31:0] rpc;
    mreq_t r;
    for (int k = 0; k < n; k++) begin
      redir = (cyc == rc1) || (cyc == rc2);
      rpc   = (cyc == rc2) ? rp2 : rp1;
      rdy   = !(cyc >= readyOffFrom && cyc < readyOffTo);
      rv    = (pend.size() > 0) && (pend[0].due <= cyc);
      gnt   = !(holdLeft > 0 && modelPc == holdAddr);
      redirect_i  = redir;
      redirect_pc = rpc;
      instr_ready = rdy;
      imem_rvalid = rv;
      imem_rdata  = rv ? ~pend[0].addr : 32'hDEAD_BEEF;
      imem_gnt    = gnt;
      #1;
      expReq   = (cyc >= 1) && !redir && ((pend.size() + bufq.size()) < DEPTH);
      expValid = (bufq.size() > 0) && !redir;
      checkOutput(expReq, expValid);
      if (imem_req && imem_gnt) gntCount++;
      if (bufq.size() > 0) lastPc = bufq[0];
      if (expValid && rdy) begin
        consumed.push_back(bufq[0]);
        void'(bufq.pop_front());
      end
      if (rv) begin
        r = pend.pop_front();
        if (!r.stale && !redir) bufq.push_back(r.addr);
      end
      if (expReq && !gnt) holdLeft--;
      if (expReq && gnt) begin
        pend.push_back('{addr: modelPc, due: cyc + lat, stale: 1'b0});
        modelPc += 32'd4;
      end
      if (redir) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        bufq.delete();
        modelPc = rpc & ~32'h3;
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic doReset();
    n_rst       = 1'b0;
    redirect_i  = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
    #1;
    compare("rst_req", imem_req, 1'b0);
    compare("rst_addr", imem_addr, 32'h0);
    compare("rst_instr", instr, 32'h0000_0013);
    compare("rst_pc", instr_pc, 32'h0);
    compare("rst_valid", instr_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    pend.delete();
    bufq.delete();
    consumed.delete();
    modelPc = 32'h0;
    lastPc = 32'h0;
    cyc = 0;
    gntCount = 0;
    lat = 1;
    holdLeft = 0;
    holdAddr = 32'h0;
    rc1 = -1;
    rc2 = -1;
    rp1 = 32'h0;
    rp2 = 32'h0;
    readyOffFrom = 0;
    readyOffTo = 0;
    for (int i = 0; i < 64; i++) begin
      logReq[i] = 1'b0;
      logAddr[i] = '0;
      logValid[i] = 1'b0;
      logPc[i] = '0;
    end
    n_rst = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    #2;

    // Streaming with immediate grants and one-cycle responses.
    doReset();
    applyStimulus(12);
    compare("A_boot_req", logReq[0], 1'b0);
    compare("A_first_req", logReq[1], 1'b1);
    compare("A_first_addr", logAddr[1], 32'h0);
    compare("A_valid_c2", logValid[2], 1'b0);
    compare("A_valid_c3", logValid[3], 1'b1);
    compare("A_pc_c3", logPc[3], 32'h0);
    compare("A_addr_c4", logAddr[4], 32'h8);
    compare("A_c0", getC(0), 32'h0);
    compare("A_c1", getC(1), 32'h4);
    compare("A_c2", getC(2), 32'h8);

    // Core stalled: credit limit caps grants at DEPTH.
    doReset();
    readyOffFrom = 0;
    readyOffTo = 11;
    applyStimulus(11);
    compare("B_gnts", gntCount, 2);
    compare("B_req_stall", logReq[10], 1'b0);
    compare("B_valid_stall", logValid[10], 1'b1);
    compare("B_pc_stall", logPc[10], 32'h0);
    applyStimulus(10);
    compare("B_c0", getC(0), 32'h0);
    compare("B_c1", getC(1), 32'h4);
    compare("B_c2", getC(2), 32'h8);
    compare("B_c3", getC(3), 32'hC);

    // Grant for 0x8 withheld three cycles.
    doReset();
    holdAddr = 32'h8;
    holdLeft = 3;
    applyStimulus(14);
    for (int i = 4; i < 8; i++) begin
      compare("C_hold_req", logReq[i], 1'b1);
      compare("C_hold_addr", logAddr[i], 32'h8);
    end
    compare("C_addr_after", logAddr[8], 32'hC);
    compare("C_c2", getC(2), 32'h8);

    // Redirect with 0x8 and 0xC in flight.
    doReset();
    lat = 4;
    rc1 = 10;
    rp1 = 32'h100;
    applyStimulus(25);
    compare("D_req_redir", logReq[10], 1'b0);
    compare("D_valid_redir", logValid[10], 1'b0);
    compare("D_new_addr", logAddr[12], 32'h100);
    compare("D_c1", getC(1), 32'h4);
    compare("D_c2", getC(2), 32'h100);
    compare("D_c3", getC(3), 32'h104);

    // Unaligned redirect during BOOT.
    doReset();
    rc1 = 0;
    rp1 = 32'h203;
    applyStimulus(8);
    compare("E_req", logReq[1], 1'b1);
    compare("E_addr", logAddr[1], 32'h200);
    compare("E_pc_c3", logPc[3], 32'h200);
    compare("E_c0", getC(0), 32'h200);

    // Back-to-back redirects, one request outstanding.
    doReset();
    lat = 3;
    rc1 = 7;
    rp1 = 32'h40;
    rc2 = 8;
    rp2 = 32'h80;
    applyStimulus(20);
    compare("F_req_r1", logReq[7], 1'b0);
    compare("F_req_r2", logReq[8], 1'b0);
    compare("F_addr", logAddr[9], 32'h80);
    compare("F_c2", getC(2), 32'h80);
    compare("F_c3", getC(3), 32'h84);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
